// File: rtl/input_snapshot_if.sv
// CPU read port of input_snapshot: address and read strobe in, registered data and interrupt out.
interface input_snapshot_if;
    logic [7:0] cpu_addr;
    logic       cpu_rd;
    logic [7:0] cpu_dout;
    logic       irq;

    modport master (output cpu_addr, output cpu_rd, input cpu_dout, input irq);
    modport slave  (input cpu_addr, input cpu_rd, output cpu_dout, output irq);
endinterface

// File: rtl/input_snapshot.sv
// Per-frame snapshot of player inputs with spinner accumulation, joystick change events
// queued in a small FIFO, and a byte-wide CPU read port.
module input_snapshot #(
    parameter int unsigned CHANNELS   = 6,
    parameter int unsigned JOY_W      = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [CHANNELS*JOY_W-1:0] joystick,
    input  logic [CHANNELS*16-1:0]    analog,
    input  logic [CHANNELS*8-1:0]     paddle,
    input  logic [CHANNELS*16-1:0]    spinner,
    input  logic                      vblank,
    input_snapshot_if.slave           bus
);
    localparam int unsigned CH_W  = 3;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(CHANNELS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        SCAN = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CH_W-1:0] scan_idx_q, scan_idx_d;
    logic            vblank_q;
    logic            vb_edge_c;
    logic            snap_en_c;
    logic            scan_push_c;
    logic            overrun_set_c;

    logic [CHANNELS-1:0]            spin_tog_q, spin_tog_c;
    logic [CHANNELS-1:0][15:0]      spin_acc_q, spin_acc_d;
    logic [CHANNELS-1:0][JOY_W-1:0] snap_joy_q, prev_joy_q;
    logic [CHANNELS-1:0][15:0]      snap_ana_q, snap_spin_q;
    logic [CHANNELS-1:0][7:0]       snap_pad_q;
    logic [7:0]                     frame_q;

    logic [CH_W-1:0]  fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             fifo_empty_c, fifo_full_c;
    logic             pop_c, push_ok_c, ovf_set_c, stat_rd_c;
    logic             overflow_q, overflow_d, overrun_q, overrun_d;

    logic [7:0]      rd_data_c;
    logic [3:0]      count_sat_c;
    logic [3:0]      ch_sel_c;
    logic [CH_W-1:0] ch_idx_c;
    logic [31:0]     joy_word_c;
    logic [7:0]      dout_q;
    logic            irq_q;
    logic            unused_spin_c;

    assign vb_edge_c     = vblank & ~vblank_q;
    assign unused_spin_c = ^spinner;

    // Spinner accumulators: a flipped update toggle adds the sign-extended delta.
    always_comb begin
        spin_tog_c = '0;
        spin_acc_d = spin_acc_q;
        for (int unsigned ch = 0; ch < CHANNELS; ch++) begin
            spin_tog_c[ch] = spinner[ch*16+8];
            if (spinner[ch*16+8] != spin_tog_q[ch]) begin
                spin_acc_d[ch] = spin_acc_q[ch] + {{8{spinner[ch*16+7]}}, spinner[ch*16 +: 8]};
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            scan_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
        end
    end

    // Next-state: one snapshot cycle, then one channel compared per cycle.
    always_comb begin
        state_d       = state_q;
        scan_idx_d    = scan_idx_q;
        snap_en_c     = 1'b0;
        scan_push_c   = 1'b0;
        overrun_set_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (vb_edge_c) state_d = SNAP;
            end
            SNAP: begin
                snap_en_c     = 1'b1;
                overrun_set_c = vb_edge_c;
                scan_idx_d    = '0;
                state_d       = SCAN;
            end
            SCAN: begin
                overrun_set_c = vb_edge_c;
                scan_push_c   = snap_joy_q[scan_idx_q] != prev_joy_q[scan_idx_q];
                if (scan_idx_q == LAST_CH) begin
                    state_d = IDLE;
                end else begin
                    scan_idx_d = scan_idx_q + CH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the same cycle pops the head.
    always_comb begin
        fifo_empty_c = (count_q == '0);
        fifo_full_c  = (count_q == CNT_W'(FIFO_DEPTH));
        stat_rd_c    = bus.cpu_rd && (bus.cpu_addr == 8'h00);
        pop_c        = bus.cpu_rd && (bus.cpu_addr == 8'h01) && !fifo_empty_c;
        push_ok_c    = scan_push_c && (!fifo_full_c || pop_c);
        ovf_set_c    = scan_push_c && !push_ok_c;
        count_d      = count_q;
        if (push_ok_c && !pop_c) count_d = count_q + CNT_W'(1);
        if (pop_c && !push_ok_c) count_d = count_q - CNT_W'(1);
        overflow_d   = ovf_set_c | (overflow_q & ~stat_rd_c);
        overrun_d    = overrun_set_c | (overrun_q & ~stat_rd_c);
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok_c) fifo_mem_q[wr_ptr_q] <= scan_idx_q;
    end

    // Read mux; channel blocks start at 0x10 with a 16-byte stride.
    assign ch_sel_c = bus.cpu_addr[7:4] - 4'd1;
    assign ch_idx_c = ch_sel_c[CH_W-1:0];

    always_comb begin
        rd_data_c   = 8'h00;
        joy_word_c  = '0;
        count_sat_c = (32'(count_q) > 32'd15) ? 4'hF : 4'(count_q);
        case (bus.cpu_addr)
            8'h00: rd_data_c = {overflow_q, overrun_q, fifo_empty_c, 1'b0, count_sat_c};
            8'h01: rd_data_c = fifo_empty_c ? 8'hFF
                                            : {{(8-CH_W){1'b0}}, fifo_mem_q[rd_ptr_q]};
            8'h02: rd_data_c = frame_q;
            default: begin
                if ((bus.cpu_addr[7:4] != 4'd0) && (32'(ch_sel_c) < CHANNELS)) begin
                    joy_word_c = 32'(snap_joy_q[ch_idx_c]);
                    case (bus.cpu_addr[3:0])
                        4'd0, 4'd1, 4'd2, 4'd3:
                               rd_data_c = joy_word_c[{bus.cpu_addr[1:0], 3'b000} +: 8];
                        4'd4:  rd_data_c = snap_ana_q[ch_idx_c][7:0];
                        4'd5:  rd_data_c = snap_ana_q[ch_idx_c][15:8];
                        4'd6:  rd_data_c = snap_pad_q[ch_idx_c];
                        4'd7:  rd_data_c = snap_spin_q[ch_idx_c][7:0];
                        4'd8:  rd_data_c = snap_spin_q[ch_idx_c][15:8];
                        default: rd_data_c = 8'h00;
                    endcase
                end
            end
        endcase
    end

    // Toggle and vblank history track the inputs through reset so no false update follows it.
    always_ff @(posedge clk_sys) begin
        spin_tog_q <= spin_tog_c;
        vblank_q   <= vblank;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            spin_acc_q  <= '0;
            snap_joy_q  <= '0;
            prev_joy_q  <= '0;
            snap_ana_q  <= '0;
            snap_pad_q  <= '0;
            snap_spin_q <= '0;
            frame_q     <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            overrun_q   <= 1'b0;
            dout_q      <= 8'h00;
            irq_q       <= 1'b0;
        end else begin
            spin_acc_q <= spin_acc_d;
            if (snap_en_c) begin
                snap_joy_q  <= joystick;
                prev_joy_q  <= snap_joy_q;
                snap_ana_q  <= analog;
                snap_pad_q  <= paddle;
                snap_spin_q <= spin_acc_q;
                frame_q     <= frame_q + 8'd1;
            end
            if (push_ok_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q    <= count_d;
            overflow_q <= overflow_d;
            overrun_q  <= overrun_d;
            if (bus.cpu_rd) dout_q <= rd_data_c;
            irq_q      <= (count_d != '0);
        end
    end

    assign bus.cpu_dout = dout_q;
    assign bus.irq      = irq_q;
endmodule

// File: tb/tb_input_snapshot.sv
// Directed bench for input_snapshot: reads queue expected bytes, a monitor checks cpu_dout.
module tb_input_snapshot;
    localparam int unsigned CH = 6;
    localparam int unsigned JW = 32;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic [CH*JW-1:0]  joystick = '0;
    logic [CH*16-1:0]  analog = '0;
    logic [CH*8-1:0]   paddle = '0;
    logic [CH*16-1:0]  spinner = '0;
    logic              vblank = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];
    logic [7:0] addr_q[$];
    logic       rd_d = 1'b0;

    input_snapshot_if bus();

    input_snapshot #(.CHANNELS(CH), .JOY_W(JW), .FIFO_DEPTH(4)) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .joystick (joystick),
        .analog   (analog),
        .paddle   (paddle),
        .spinner  (spinner),
        .vblank   (vblank),
        .bus      (bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%02h exp=%02h", nm, got, exp);
        end
    endtask

    always @(posedge clk_sys) rd_d <= bus.cpu_rd;

    // Monitor: every accepted read presents data one cycle later.
    always @(negedge clk_sys) begin
        if (rd_d) begin
            if (exp_q.size() == 0) begin
                check("rd_unexpected", bus.cpu_dout, 8'h00);
            end else begin
                logic [7:0] e, a;
                e = exp_q.pop_front();
                a = addr_q.pop_front();
                check($sformatf("rd_%02h", a), bus.cpu_dout, e);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [7:0] e);
        @(negedge clk_sys);
        bus.cpu_addr = a;
        bus.cpu_rd   = 1'b1;
        exp_q.push_back(e);
        addr_q.push_back(a);
        @(negedge clk_sys);
        bus.cpu_rd   = 1'b0;
    endtask

    task automatic vblank_pulse();
        @(negedge clk_sys);
        vblank = 1'b1;
        @(negedge clk_sys);
        vblank = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cpu_addr = 8'h00;
        bus.cpu_rd   = 1'b0;
        idle(3);
        reset_n = 1'b1;
        idle(1);

        // Reset state
        check("irq_reset", {7'd0, bus.irq}, 8'h00);
        check("dout_reset", bus.cpu_dout, 8'h00);
        cpu_read(8'h00, 8'h20);
        cpu_read(8'h02, 8'h00);
        cpu_read(8'h10, 8'h00);

        // Single joystick change produces one event
        joystick[0 +: JW] = 32'h0000_0001;
        vblank_pulse();
        idle(1 + CH + 2);
        check("irq_event", {7'd0, bus.irq}, 8'h01);
        cpu_read(8'h00, 8'h01);
        cpu_read(8'h01, 8'h00);
        check("irq_after_pop", {7'd0, bus.irq}, 8'h00);
        cpu_read(8'h01, 8'hFF);
        cpu_read(8'h02, 8'h01);
        cpu_read(8'h10, 8'h01);
        cpu_read(8'h11, 8'h00);

        // Spinner accumulation, analog and paddle capture
        spinner[1*16 +: 16] = {7'd0, 1'b1, 8'h05}; idle(1);
        spinner[1*16 +: 16] = {7'd0, 1'b0, 8'h05}; idle(1);
        spinner[1*16 +: 16] = {7'd0, 1'b1, 8'h05}; idle(1);
        spinner[1*16 +: 16] = {7'd0, 1'b0, 8'hFE}; idle(1);
        spinner[3*16 +: 16] = {7'h7F, 1'b1, 8'hFF}; idle(1);
        analog[2*16 +: 16]  = {8'h7F, 8'h81};
        paddle[2*8 +: 8]    = 8'hA5;
        vblank_pulse();
        idle(1 + CH + 2);
        paddle[2*8 +: 8]    = 8'h11;
        analog[2*16 +: 16]  = 16'h0000;
        cpu_read(8'h27, 8'h0D);
        cpu_read(8'h28, 8'h00);
        cpu_read(8'h47, 8'hFF);
        cpu_read(8'h48, 8'hFF);
        cpu_read(8'h34, 8'h81);
        cpu_read(8'h35, 8'h7F);
        cpu_read(8'h36, 8'hA5);
        cpu_read(8'h00, 8'h20);
        cpu_read(8'h19, 8'h00);
        cpu_read(8'h03, 8'h00);
        cpu_read(8'h80, 8'h00);

        // Two frames of full change with no reads: FIFO fills and overflows
        for (int k = 0; k < CH; k++) joystick[k*JW +: JW] = 32'h1122_3344 + 32'(k);
        vblank_pulse();
        idle(1 + CH + 2);
        for (int k = 0; k < CH; k++) joystick[k*JW +: JW] = ~(32'h1122_3344 + 32'(k));
        vblank_pulse();
        idle(1 + CH + 2);
        check("irq_full", {7'd0, bus.irq}, 8'h01);
        cpu_read(8'h00, 8'h84);
        cpu_read(8'h00, 8'h04);
        cpu_read(8'h02, 8'h04);
        cpu_read(8'h10, 8'hBB);
        cpu_read(8'h11, 8'hCC);
        cpu_read(8'h12, 8'hDD);
        cpu_read(8'h13, 8'hEE);
        cpu_read(8'h60, 8'hB6);
        cpu_read(8'h70, 8'h00);
        cpu_read(8'h01, 8'h00);
        cpu_read(8'h01, 8'h01);
        cpu_read(8'h01, 8'h02);
        cpu_read(8'h01, 8'h03);
        cpu_read(8'h01, 8'hFF);
        check("irq_drained", {7'd0, bus.irq}, 8'h00);

        // Second edge two cycles after the first is ignored and flagged
        vblank_pulse();
        vblank_pulse();
        idle(1 + CH + 2);
        cpu_read(8'h00, 8'h60);
        cpu_read(8'h02, 8'h05);
        cpu_read(8'h00, 8'h20);

        // Frame counter wrap
        for (int f = 0; f < 250; f++) begin
            vblank_pulse();
            idle(1 + CH + 1);
        end
        cpu_read(8'h02, 8'hFF);
        vblank_pulse();
        idle(1 + CH + 2);
        cpu_read(8'h02, 8'h00);

        // Reset during SCAN discards the partial scan
        joystick = '0;
        vblank_pulse();
        idle(2);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        idle(1 + CH + 2);
        check("irq_after_reset", {7'd0, bus.irq}, 8'h00);
        cpu_read(8'h00, 8'h20);
        cpu_read(8'h02, 8'h00);
        cpu_read(8'h10, 8'h00);
        cpu_read(8'h01, 8'hFF);

        idle(3);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_reads got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
